trisc_mem_arbiter: RTL

- Shares the single-port TRISC program/data RAM between two requesters: the CPU control FSM (fetch, LDA, STA, ADD operand reads) and the front-panel program loader.
- Each access is a fixed multi-cycle transaction. The block grants one requester, drives the RAM for WAIT cycles, and returns read data with a one-cycle done pulse.
- Sits between the CPU datapath/loader and the RAM. The CPU FSM stalls on its memory states until cpu_done.

---
 rtl/trisc_mem_arbiter_if.sv | 40 ++++
 rtl/trisc_mem_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/trisc_mem_arbiter_if.sv
// trisc_mem_arbiter_if: request, grant and RAM bus signals shared by the CPU FSM, the loader and the RAM arbiter.
interface trisc_mem_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
) ();
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_done;
  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_lock;
  logic          ldr_gnt;
  logic          ldr_done;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    input  mem_rdata,
    output cpu_gnt, cpu_done, ldr_gnt, ldr_done, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    output mem_rdata,
    input  cpu_gnt, cpu_done, ldr_gnt, ldr_done, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/trisc_mem_arbiter.sv
// trisc_mem_arbiter: round-robin arbiter giving the CPU FSM or the program loader fixed WAIT-cycle
// transactions on the single-port TRISC RAM; every output is registered.
module trisc_mem_arbiter #(
  parameter int AW   = 4,
  parameter int DW   = 8,
  parameter int WAIT = 2
) (
  input logic             SysClock,
  input logic             StartStop,
  trisc_mem_arbiter_if.slave bus
);
  localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          cpu_gnt_q, cpu_gnt_d;
  logic          ldr_gnt_q, ldr_gnt_d;
  logic          cpu_done_q, cpu_done_d;
  logic          ldr_done_q, ldr_done_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          busy_q, busy_d;
  logic          cpu_elig, ldr_elig, grant, pick_ldr, take, acc_end;
  always_ff @(posedge SysClock)
    if (!StartStop) state_q <= IDLE;
    else state_q <= state_d;
  // last_q/owner encoding: 1 = loader, 0 = CPU; reset to loader so the CPU wins the first tie
  always_comb begin
    cpu_elig = bus.cpu_req & ~bus.ldr_lock;
    ldr_elig = bus.ldr_req;
    grant    = cpu_elig | ldr_elig;
    pick_ldr = ldr_elig & (~cpu_elig | ~last_q);
    take     = (state_q == IDLE) && grant;
    acc_end  = (state_q == ACCESS) && (cnt_q == CNT_LAST);
    state_d  = (state_q == IDLE)   ? (grant ? ACCESS : IDLE) :
               (state_q == ACCESS) ? (acc_end ? DONE : ACCESS) : IDLE;
  end
  always_comb begin
    last_d  = take ? pick_ldr : last_q;
    we_d    = take ? (pick_ldr ? bus.ldr_we : bus.cpu_we) : we_q;
    addr_d  = take ? (pick_ldr ? bus.ldr_addr : bus.cpu_addr) : addr_q;
    wdata_d = take ? (pick_ldr ? bus.ldr_wdata : bus.cpu_wdata) : wdata_q;
    cnt_d   = (state_q == ACCESS) ? cnt_q + CW'(1) : '0;
    rdata_d = (acc_end && !we_q) ? bus.mem_rdata : rdata_q;
  end
  // outputs are derived from the next state so they appear registered in the cycle they describe
  always_comb begin
    busy_d     = state_d != IDLE;
    mem_en_d   = state_d == ACCESS;
    mem_we_d   = mem_en_d & we_d;
    cpu_gnt_d  = busy_d & ~last_d;
    ldr_gnt_d  = busy_d & last_d;
    cpu_done_d = (state_d == DONE) & ~last_d;
    ldr_done_d = (state_d == DONE) & last_d;
  end
  always_ff @(posedge SysClock)
    if (!StartStop) begin
      cnt_q      <= '0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cpu_gnt_q  <= 1'b0;
      ldr_gnt_q  <= 1'b0;
      cpu_done_q <= 1'b0;
      ldr_done_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cpu_gnt_q  <= cpu_gnt_d;
      ldr_gnt_q  <= ldr_gnt_d;
      cpu_done_q <= cpu_done_d;
      ldr_done_q <= ldr_done_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
    end
  assign bus.cpu_gnt   = cpu_gnt_q;
  assign bus.ldr_gnt   = ldr_gnt_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.ldr_done  = ldr_done_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
endmodule
